// File: rtl/mem_req_pkg.sv
// Shared types and constants for the EBOX->MBOX memory request sequencer.
package mem_req_pkg;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    READ_AR  = 3'd1,
    READ_ARX = 3'd2,
    FETCH    = 3'd3,
    RPW      = 3'd4,
    WRITE    = 3'd5
  } req_type_e;

  typedef struct packed {
    logic user;
    logic pub;
    logic prev;
    logic ext;
  } req_ctx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WREQ  = 2'd3
  } state_e;

  localparam logic [2:0] DIAG_HELD  = 3'd0;
  localparam logic [2:0] DIAG_STATE = 3'd1;
  localparam logic [2:0] DIAG_VA    = 3'd2;
  localparam logic [2:0] DIAG_BRK   = 3'd3;

  // Codes 0, 6 and 7 are accepted on the bus but never issued.
  function automatic logic type_legal(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

endpackage

// File: rtl/mem_req_seq_if.sv
// EBOX request and MBOX cycle signals; slave is the sequencer side.
interface mem_req_seq_if #(
  parameter int VA_W = 30
);
  import mem_req_pkg::*;

  logic            ebox_req_valid;
  logic            ebox_req_ready;
  logic [2:0]      ebox_req_type;
  req_ctx_t        ebox_req_ctx;
  logic [VA_W-1:0] ebox_req_va;
  logic            ebox_wr_go;

  logic            mbox_req;
  logic            mbox_ack;
  logic [2:0]      mbox_type;
  req_ctx_t        mbox_ctx;
  logic [VA_W-1:0] mbox_va;

  modport master (
    output ebox_req_valid, ebox_req_type, ebox_req_ctx, ebox_req_va, ebox_wr_go, mbox_ack,
    input  ebox_req_ready, mbox_req, mbox_type, mbox_ctx, mbox_va
  );

  modport slave (
    input  ebox_req_valid, ebox_req_type, ebox_req_ctx, ebox_req_va, ebox_wr_go, mbox_ack,
    output ebox_req_ready, mbox_req, mbox_type, mbox_ctx, mbox_va
  );

endinterface

// File: rtl/req_fifo.sv
// Small show-ahead request queue; dout is the head entry whenever empty is low.
module req_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only entries below count are ever treated as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_seq.sv
// EBOX->MBOX memory request sequencer: queues requests and issues one MBOX cycle at a time.
// Optional address-break compare is built when MEM_REQ_ADR_BRK_EN is defined.
module mem_req_seq
  import mem_req_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int VA_W       = 30,
  parameter int VA_LEGAL_W = 23
) (
  input  logic         clk,
  input  logic         RESET,
  mem_req_seq_if.slave bus,
  input  logic         adr_err_clr,
  output logic         vma_pause,
  output logic         adr_err,
  input  logic [2:0]   diag_sel,
  output logic [7:0]   diag_data
`ifdef MEM_REQ_ADR_BRK_EN
  ,
  input  logic [VA_W-1:0] brk_va,
  input  logic [2:0]      brk_en,
  input  logic            brk_user,
  output logic            page_addr_cond
`endif
);

  localparam int ENTRY_W = 3 + $bits(req_ctx_t) + VA_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               accept, type_ok, va_bad, push, adr_err_set;
  logic [VA_W-1:0]    va_in;
  logic [ENTRY_W-1:0] q_head;
  logic [2:0]         q_type;
  req_ctx_t           q_ctx;
  logic [VA_W-1:0]    q_va;
  logic               q_full, q_empty;
  logic [CNT_W-1:0]   q_count;
  state_e             state_q, state_d;
  logic               pop, load_req, load_wr;
  logic [2:0]         mbox_type_q, held_type;
  req_ctx_t           mbox_ctx_q, held_ctx;
  logic [VA_W-1:0]    mbox_va_q;

  assign accept  = bus.ebox_req_valid & bus.ebox_req_ready;
  assign type_ok = type_legal(bus.ebox_req_type);

  if (VA_LEGAL_W < VA_W) begin : g_va_chk
    assign va_bad = bus.ebox_req_ctx.ext & (|bus.ebox_req_va[VA_W-1:VA_LEGAL_W]);
  end else begin : g_va_all_legal
    assign va_bad = 1'b0;
  end

  // An illegal type is dropped silently, even when its address is also bad.
  assign adr_err_set = accept & type_ok & va_bad;
  assign push        = accept & type_ok & ~va_bad;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    va_in = bus.ebox_req_va;
    if (!bus.ebox_req_ctx.ext) va_in[VA_W-1:18] = '0;
  end

  // The in-flight request stays in the queue until its first ack, so it still counts against ready.
  req_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .RESET (RESET),
    .push  (push),
    .din   ({bus.ebox_req_type, bus.ebox_req_ctx, va_in}),
    .pop   (pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );
  assign {q_type, q_ctx, q_va} = q_head;
  assign bus.ebox_req_ready    = ~q_full;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_req = 1'b0;
    load_wr  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (!q_empty) begin
                  state_d  = ST_REQ;
                  load_req = 1'b1;
                end
      ST_REQ:   if (bus.mbox_ack) begin
                  pop     = 1'b1;
                  state_d = (mbox_type_q == RPW) ? ST_PAUSE : ST_IDLE;
                end
      ST_PAUSE: if (bus.ebox_wr_go) begin
                  state_d = ST_WREQ;
                  load_wr = 1'b1;
                end
      ST_WREQ:  if (bus.mbox_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      mbox_type_q <= '0;
      mbox_ctx_q  <= '0;
      mbox_va_q   <= '0;
      held_type   <= '0;
      held_ctx    <= '0;
    end else if (load_req) begin
      mbox_type_q <= q_type;
      mbox_ctx_q  <= q_ctx;
      mbox_va_q   <= q_va;
      held_type   <= q_type;
      held_ctx    <= q_ctx;
    end else if (load_wr) begin
      mbox_type_q <= WRITE;
      held_type   <= WRITE;
      held_ctx    <= mbox_ctx_q;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)            adr_err <= 1'b0;
    else if (adr_err_clr) adr_err <= 1'b0;
    else if (adr_err_set) adr_err <= 1'b1;
  end

  assign bus.mbox_req  = (state_q == ST_REQ) || (state_q == ST_WREQ);
  assign bus.mbox_type = mbox_type_q;
  assign bus.mbox_ctx  = mbox_ctx_q;
  assign bus.mbox_va   = mbox_va_q;
  assign vma_pause     = (state_q == ST_PAUSE);

`ifdef MEM_REQ_ADR_BRK_EN
  logic class_en, hit_req, hit_wr;

  always_comb begin
    class_en = 1'b0;
    case (q_type)
      FETCH:              class_en = brk_en[2];
      READ_AR, READ_ARX,
      RPW:                class_en = brk_en[1];
      WRITE:              class_en = brk_en[0];
      default:            class_en = 1'b0;
    endcase
  end

  // Both issue points re-evaluate the compare; the write half of an RPW is a write-class issue.
  assign hit_req = (q_va == brk_va) && class_en && (q_ctx.user == brk_user);
  assign hit_wr  = (mbox_va_q == brk_va) && brk_en[0] && (mbox_ctx_q.user == brk_user);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)         page_addr_cond <= 1'b0;
    else if (load_req) page_addr_cond <= hit_req;
    else if (load_wr)  page_addr_cond <= hit_wr;
  end
`endif

  always_comb begin
    diag_data = '0;
    case (diag_sel)
      DIAG_HELD:  diag_data = {held_type, held_ctx, 1'b0};
      DIAG_STATE: diag_data = {1'b0, state_q, 4'(q_count), adr_err};
      DIAG_VA:    diag_data = mbox_va_q[7:0];
`ifdef MEM_REQ_ADR_BRK_EN
      DIAG_BRK:   diag_data = {page_addr_cond, 7'b0};
`endif
      default:    diag_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_req_seq.sv
// Directed bench for mem_req_seq: each scenario task drives the bus and checks hand-computed values.
module tb_mem_req_seq;

  logic       clk = 1'b0;
  logic       RESET;
  logic       adr_err_clr;
  logic       vma_pause;
  logic       adr_err;
  logic [2:0] diag_sel;
  logic [7:0] diag_data;
`ifdef MEM_REQ_ADR_BRK_EN
  logic [29:0] brk_va;
  logic [2:0]  brk_en;
  logic        brk_user;
  logic        page_addr_cond;
`endif

  int checks = 0;
  int passed = 0;

  mem_req_seq_if #(.VA_W(30)) bus ();

  mem_req_seq #(.DEPTH(2), .VA_W(30), .VA_LEGAL_W(23)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .bus         (bus),
    .adr_err_clr (adr_err_clr),
    .vma_pause   (vma_pause),
    .adr_err     (adr_err),
    .diag_sel    (diag_sel),
    .diag_data   (diag_data)
`ifdef MEM_REQ_ADR_BRK_EN
    ,
    .brk_va         (brk_va),
    .brk_en         (brk_en),
    .brk_user       (brk_user),
    .page_addr_cond (page_addr_cond)
`endif
  );

  always #5 clk = ~clk;

  // Called at a falling edge; presents one request for exactly one rising edge.
  task automatic send(input logic [2:0] t, input logic [3:0] c, input logic [29:0] va);
    bus.ebox_req_valid = 1'b1;
    bus.ebox_req_type  = t;
    bus.ebox_req_ctx   = c;
    bus.ebox_req_va    = va;
    @(negedge clk);
    bus.ebox_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL rst_mbox_req: got %0b want 0", bus.mbox_req); else passed++;
    checks++; if (vma_pause !== 1'b0) $display("FAIL rst_vma_pause: got %0b want 0", vma_pause); else passed++;
    checks++; if (adr_err !== 1'b0) $display("FAIL rst_adr_err: got %0b want 0", adr_err); else passed++;
    checks++; if (bus.ebox_req_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", bus.ebox_req_ready); else passed++;
    checks++; if (bus.mbox_va !== 30'd0) $display("FAIL rst_mbox_va: got %0h want 0", bus.mbox_va); else passed++;
    for (int s = 0; s < 4; s++) begin
      diag_sel = 3'(s);
      #1;
      checks++; if (diag_data !== 8'h00) $display("FAIL rst_diag%0d: got %02h want 00", s, diag_data); else passed++;
    end
    diag_sel = 3'd0;
    RESET    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    send(3'd1, 4'b0000, 30'o1234);
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL rd_req_early: got %0b want 0", bus.mbox_req); else passed++;
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b1) $display("FAIL rd_req: got %0b want 1", bus.mbox_req); else passed++;
    checks++; if (bus.mbox_type !== 3'd1) $display("FAIL rd_type: got %0d want 1", bus.mbox_type); else passed++;
    checks++; if (bus.mbox_va !== 30'o1234) $display("FAIL rd_va: got %0o want 1234", bus.mbox_va); else passed++;
    bus.mbox_ack    = 1'b1;
    bus.ebox_wr_go  = 1'b1;
    @(negedge clk);
    bus.mbox_ack    = 1'b0;
    bus.ebox_wr_go  = 1'b0;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL rd_idle_req: got %0b want 0", bus.mbox_req); else passed++;
    checks++; if (vma_pause !== 1'b0) $display("FAIL rd_wrgo_ignored: vma_pause=%0b want 0", vma_pause); else passed++;
    diag_sel = 3'd0; #1;
    checks++; if (diag_data !== 8'h20) $display("FAIL rd_held: got %02h want 20", diag_data); else passed++;
    diag_sel = 3'd1; #1;
    checks++; if (diag_data !== 8'h00) $display("FAIL rd_state: got %02h want 00", diag_data); else passed++;
    diag_sel = 3'd2; #1;
    checks++; if (diag_data !== 8'h9C) $display("FAIL rd_diag_va: got %02h want 9c", diag_data); else passed++;
    @(negedge clk);
  endtask

  task automatic test_rpw();
    send(3'd4, 4'b0000, 30'o500);
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b1) $display("FAIL rpw_req: got %0b want 1", bus.mbox_req); else passed++;
    checks++; if (bus.mbox_type !== 3'd4) $display("FAIL rpw_type: got %0d want 4", bus.mbox_type); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    checks++; if (vma_pause !== 1'b1) $display("FAIL rpw_pause: got %0b want 1", vma_pause); else passed++;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL rpw_pause_req: got %0b want 0", bus.mbox_req); else passed++;
    diag_sel = 3'd1; #1;
    checks++; if (diag_data !== 8'h40) $display("FAIL rpw_state: got %02h want 40", diag_data); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (vma_pause !== 1'b1) $display("FAIL rpw_pause_hold: got %0b want 1", vma_pause); else passed++;
    bus.ebox_wr_go = 1'b1;
    @(negedge clk);
    bus.ebox_wr_go = 1'b0;
    checks++; if (vma_pause !== 1'b0) $display("FAIL wreq_pause: got %0b want 0", vma_pause); else passed++;
    checks++; if (bus.mbox_req !== 1'b1) $display("FAIL wreq_req: got %0b want 1", bus.mbox_req); else passed++;
    checks++; if (bus.mbox_type !== 3'd5) $display("FAIL wreq_type: got %0d want 5", bus.mbox_type); else passed++;
    checks++; if (bus.mbox_va !== 30'o500) $display("FAIL wreq_va: got %0o want 500", bus.mbox_va); else passed++;
    diag_sel = 3'd0; #1;
    checks++; if (diag_data !== 8'hA0) $display("FAIL wreq_held: got %02h want a0", diag_data); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL wreq_done: got %0b want 0", bus.mbox_req); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.ebox_req_valid = 1'b1;
    bus.ebox_req_ctx   = 4'b0000;
    bus.ebox_req_type  = 3'd1;
    bus.ebox_req_va    = 30'd1;
    checks++; if (bus.ebox_req_ready !== 1'b1) $display("FAIL b2b_ready_a: got %0b want 1", bus.ebox_req_ready); else passed++;
    @(negedge clk);
    bus.ebox_req_type = 3'd3;
    bus.ebox_req_va   = 30'd2;
    checks++; if (bus.ebox_req_ready !== 1'b1) $display("FAIL b2b_ready_b: got %0b want 1", bus.ebox_req_ready); else passed++;
    @(negedge clk);
    bus.ebox_req_type = 3'd2;
    bus.ebox_req_va   = 30'd3;
    checks++; if (bus.ebox_req_ready !== 1'b0) $display("FAIL b2b_full: got %0b want 0", bus.ebox_req_ready); else passed++;
    checks++; if (bus.mbox_va !== 30'd1) $display("FAIL b2b_va_a: got %0h want 1", bus.mbox_va); else passed++;
    @(negedge clk);
    checks++; if (bus.ebox_req_ready !== 1'b0) $display("FAIL b2b_stall: got %0b want 0", bus.ebox_req_ready); else passed++;
    checks++; if (bus.mbox_va !== 30'd1) $display("FAIL b2b_va_stable: got %0h want 1", bus.mbox_va); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    checks++; if (bus.ebox_req_ready !== 1'b1) $display("FAIL b2b_ready_after_ack: got %0b want 1", bus.ebox_req_ready); else passed++;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL b2b_gap_a: got %0b want 0", bus.mbox_req); else passed++;
    @(negedge clk);
    bus.ebox_req_valid = 1'b0;
    checks++; if (bus.mbox_type !== 3'd3 || bus.mbox_va !== 30'd2) $display("FAIL b2b_second: got type %0d va %0h want 3/2", bus.mbox_type, bus.mbox_va); else passed++;
    diag_sel = 3'd1; #1;
    checks++; if (diag_data !== 8'h24) $display("FAIL b2b_state: got %02h want 24", diag_data); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL b2b_gap_b: got %0b want 0", bus.mbox_req); else passed++;
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b1 || bus.mbox_type !== 3'd2 || bus.mbox_va !== 30'd3) $display("FAIL b2b_third: got req %0b type %0d va %0h want 1/2/3", bus.mbox_req, bus.mbox_type, bus.mbox_va); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    #1;
    checks++; if (diag_data !== 8'h00) $display("FAIL b2b_drained: got %02h want 00", diag_data); else passed++;
    @(negedge clk);
  endtask

  task automatic test_adr_err();
    diag_sel = 3'd1;
    send(3'd1, 4'b0001, 30'h0200_0000);
    #1;
    checks++; if (adr_err !== 1'b1) $display("FAIL ae_bit25: got %0b want 1", adr_err); else passed++;
    checks++; if (diag_data !== 8'h01) $display("FAIL ae_dropped: got %02h want 01", diag_data); else passed++;
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL ae_no_req: got %0b want 0", bus.mbox_req); else passed++;
    adr_err_clr = 1'b1;
    @(negedge clk);
    adr_err_clr = 1'b0;
    checks++; if (adr_err !== 1'b0) $display("FAIL ae_clr: got %0b want 0", adr_err); else passed++;
    adr_err_clr = 1'b1;
    send(3'd1, 4'b0001, 30'h0200_0000);
    adr_err_clr = 1'b0;
    checks++; if (adr_err !== 1'b0) $display("FAIL ae_clr_priority: got %0b want 0", adr_err); else passed++;
    send(3'd2, 4'b0001, 30'h0080_0000);
    checks++; if (adr_err !== 1'b1) $display("FAIL ae_bit23: got %0b want 1", adr_err); else passed++;
    adr_err_clr = 1'b1;
    @(negedge clk);
    adr_err_clr = 1'b0;
    send(3'd7, 4'b0001, 30'h0200_0000);
    checks++; if (adr_err !== 1'b0) $display("FAIL ae_illegal_type: got %0b want 0", adr_err); else passed++;
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL ae_illegal_no_req: got %0b want 0", bus.mbox_req); else passed++;
    send(3'd1, 4'b0001, 30'h0040_0000);
    checks++; if (adr_err !== 1'b0) $display("FAIL ae_bit22_legal: got %0b want 0", adr_err); else passed++;
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b1 || bus.mbox_va !== 30'h0040_0000) $display("FAIL ae_ext_va: got req %0b va %0h want 1/400000", bus.mbox_req, bus.mbox_va); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    send(3'd3, 4'b0000, 30'h0204_0012);
    @(negedge clk);
    checks++; if (bus.mbox_va !== 30'h0000_0012) $display("FAIL ae_nonext_mask: got %0h want 12", bus.mbox_va); else passed++;
    checks++; if (adr_err !== 1'b0) $display("FAIL ae_nonext_no_err: got %0b want 0", adr_err); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    send(3'd1, 4'b0001, 30'h0200_0000);
    send(3'd4, 4'b0000, 30'o700);
    @(negedge clk);
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    checks++; if (vma_pause !== 1'b1 || adr_err !== 1'b1) $display("FAIL rm_setup: got pause %0b adr_err %0b want 1/1", vma_pause, adr_err); else passed++;
    RESET        = 1'b1;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    checks++; if (vma_pause !== 1'b0) $display("FAIL rm_pause: got %0b want 0", vma_pause); else passed++;
    checks++; if (bus.mbox_req !== 1'b0) $display("FAIL rm_req: got %0b want 0", bus.mbox_req); else passed++;
    checks++; if (adr_err !== 1'b0) $display("FAIL rm_adr_err: got %0b want 0", adr_err); else passed++;
    checks++; if (bus.mbox_type !== 3'd0 || bus.mbox_va !== 30'd0) $display("FAIL rm_desc: got type %0d va %0o want 0/0", bus.mbox_type, bus.mbox_va); else passed++;
    for (int s = 0; s < 3; s++) begin
      diag_sel = 3'(s);
      #1;
      checks++; if (diag_data !== 8'h00) $display("FAIL rm_diag%0d: got %02h want 00", s, diag_data); else passed++;
    end
    RESET = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.mbox_req !== 1'b0 || vma_pause !== 1'b0) $display("FAIL rm_stale_ack: got req %0b pause %0b want 0/0", bus.mbox_req, vma_pause); else passed++;
    diag_sel = 3'd1; #1;
    checks++; if (diag_data !== 8'h00) $display("FAIL rm_idle: got %02h want 00", diag_data); else passed++;
    bus.mbox_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_brk();
`ifdef MEM_REQ_ADR_BRK_EN
    brk_va   = 30'o777;
    brk_en   = 3'b100;
    brk_user = 1'b0;
    send(3'd3, 4'b0000, 30'o777);
    @(negedge clk);
    checks++; if (page_addr_cond !== 1'b1) $display("FAIL brk_fetch: got %0b want 1", page_addr_cond); else passed++;
    diag_sel = 3'd3; #1;
    checks++; if (diag_data !== 8'h80) $display("FAIL brk_diag: got %02h want 80", diag_data); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    send(3'd1, 4'b0000, 30'o777);
    @(negedge clk);
    checks++; if (page_addr_cond !== 1'b0) $display("FAIL brk_read: got %0b want 0", page_addr_cond); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    @(negedge clk);
`else
    send(3'd3, 4'b0000, 30'o777);
    @(negedge clk);
    diag_sel = 3'd3; #1;
    checks++; if (diag_data !== 8'h00) $display("FAIL brk_absent_diag: got %02h want 00", diag_data); else passed++;
    bus.mbox_ack = 1'b1;
    @(negedge clk);
    bus.mbox_ack = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    RESET              = 1'b1;
    adr_err_clr        = 1'b0;
    diag_sel           = 3'd0;
    bus.ebox_req_valid = 1'b0;
    bus.ebox_req_type  = 3'd0;
    bus.ebox_req_ctx   = 4'b0000;
    bus.ebox_req_va    = 30'd0;
    bus.ebox_wr_go     = 1'b0;
    bus.mbox_ack       = 1'b0;
`ifdef MEM_REQ_ADR_BRK_EN
    brk_va   = 30'd0;
    brk_en   = 3'b000;
    brk_user = 1'b0;
`endif
    test_reset();
    test_read();
    test_rpw();
    test_back_to_back();
    test_adr_err();
    test_reset_mid_cycle();
    test_brk();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
